// File: rtl/dmux_gate_pkg.sv
// Shared opcode encoding and width constants for the gate router.
package dmux_gate_pkg;

  localparam int OP_W  = 3;
  localparam int CNT_W = 16;

  typedef enum logic [OP_W-1:0] {
    OP_NAND    = 3'd0,
    OP_NOR     = 3'd1,
    OP_AND     = 3'd2,
    OP_OR      = 3'd3,
    OP_XOR     = 3'd4,
    OP_XNOR    = 3'd5,
    OP_NOT_A   = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

endpackage

// File: rtl/dmux_gate_router_if.sv
// Operand handshake plus per-channel result bus of the gate router.
interface dmux_gate_router_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) ();
  localparam int CH_W = $clog2(CHANNELS);

  logic                          in_valid;
  logic                          in_ready;
  logic [WIDTH-1:0]              in_a;
  logic [WIDTH-1:0]              in_b;
  logic [dmux_gate_pkg::OP_W-1:0] in_op;
  logic [CH_W-1:0]               in_ch;
  logic [CHANNELS-1:0]           out_valid;
  logic [CHANNELS-1:0]           out_ready;
  logic [CHANNELS*WIDTH-1:0]     out_data;

  // Source/consumer side.
  modport master (
    output in_valid, in_a, in_b, in_op, in_ch, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Router side.
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_ch, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dmux_nw.sv
// 1-to-N demux: steers an enable and a data word onto the channel chosen by sel.
module dmux_nw #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CH_W     = $clog2(CHANNELS)
) (
  input  logic                      en,
  input  logic [CH_W-1:0]           sel,
  input  logic [WIDTH-1:0]          data,
  output logic [CHANNELS-1:0]       load,
  output logic [CHANNELS*WIDTH-1:0] data_out
);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    load     = '0;
    data_out = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (en && (sel == CH_W'(k))) begin
        load[k]                     = 1'b1;
        data_out[k*WIDTH +: WIDTH]  = data;
      end
    end
  end

endmodule

// File: rtl/dmux_gate_router.sv
// Pipelined bitwise-gate evaluator whose registered result is demuxed to one of
// CHANNELS single-entry, independently back-pressured output buffers.
module dmux_gate_router
  import dmux_gate_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  dmux_gate_router_if.slave bus,
  output logic             err,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int CH_W = $clog2(CHANNELS);

  logic                      s1_valid;
  logic [WIDTH-1:0]          s1_data;
  logic [CH_W-1:0]           s1_ch;
  logic [CHANNELS-1:0]       buf_valid;
  logic [WIDTH-1:0]          buf_data [CHANNELS];

  logic [WIDTH-1:0]          gate_res;
  logic                      bad_txn;
  logic                      in_fire;
  logic                      s1_move;
  logic [CHANNELS-1:0]       buf_load;
  logic [CHANNELS*WIDTH-1:0] buf_din;

  always_comb begin
    gate_res = '0;
    case (op_e'(bus.in_op))
      OP_NAND:  gate_res = ~(bus.in_a & bus.in_b);
      OP_NOR:   gate_res = ~(bus.in_a | bus.in_b);
      OP_AND:   gate_res = bus.in_a & bus.in_b;
      OP_OR:    gate_res = bus.in_a | bus.in_b;
      OP_XOR:   gate_res = bus.in_a ^ bus.in_b;
      OP_XNOR:  gate_res = ~(bus.in_a ^ bus.in_b);
      OP_NOT_A: gate_res = ~bus.in_a;
      default:  gate_res = '0;
    endcase
  end

  // Bad transactions still complete the handshake; they are just never staged.
  assign bad_txn = (bus.in_op == OP_ILLEGAL) || (int'(bus.in_ch) >= CHANNELS);

  // A held S1 can leave when its target buffer is empty or draining this cycle.
  assign s1_move     = s1_valid && (!buf_valid[s1_ch] || bus.out_ready[s1_ch]);
  assign bus.in_ready = !s1_valid || s1_move;
  assign in_fire     = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_ch    <= '0;
      err      <= 1'b0;
    end else begin
      if (in_fire && !bad_txn) begin
        s1_valid <= 1'b1;
        s1_data  <= gate_res;
        s1_ch    <= bus.in_ch;
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end
      if (in_fire && bad_txn) begin
        err <= 1'b1;
      end
    end
  end

  dmux_nw #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W)
  ) u_dmux (
    .en       (s1_move),
    .sel      (s1_ch),
    .data     (s1_data),
    .load     (buf_load),
    .data_out (buf_din)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_valid <= '0;
      // NOTE: the buffer words are a handful of flops, not a RAM, so clearing them on reset is cheap and keeps out_data defined.
      for (int k = 0; k < CHANNELS; k++) begin
        buf_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (buf_load[k]) begin
          buf_valid[k] <= 1'b1;
          buf_data[k]  <= buf_din[k*WIDTH +: WIDTH];
        end else if (bus.out_ready[k]) begin
          buf_valid[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      bus.out_data[k*WIDTH +: WIDTH] = buf_data[k];
    end
  end

  assign bus.out_valid = buf_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else begin
      done_cnt <= done_cnt + CNT_W'($countones(buf_valid & bus.out_ready));
    end
  end

endmodule

// File: tb/tb_dmux_gate_router.sv
// Directed self-checking bench for dmux_gate_router (CHANNELS=4 main, CHANNELS=6 range check).
module tb_dmux_gate_router;
  import dmux_gate_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic err, err6;
  logic [CNT_W-1:0] done_cnt, done6;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmux_gate_router_if #(.WIDTH(8), .CHANNELS(4)) bus  ();
  dmux_gate_router_if #(.WIDTH(8), .CHANNELS(6)) bus6 ();

  dmux_gate_router #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bus), .err (err), .done_cnt (done_cnt)
  );

  dmux_gate_router #(.WIDTH(8), .CHANNELS(6)) dut6 (
    .clk (clk), .rst_n (rst_n), .bus (bus6), .err (err6), .done_cnt (done6)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic [1:0] ch);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_ch    = ch;
  endtask

  function automatic logic [7:0] lane(input int k);
    return bus.out_data[k*8 +: 8];
  endfunction

  logic [7:0] sweep_exp [7] = '{8'h3F, 8'h03, 8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h0F};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0; bus.in_ch = '0;
    bus.out_ready = '1;
    bus6.in_valid = 1'b0; bus6.in_a = '0; bus6.in_b = '0; bus6.in_op = '0; bus6.in_ch = '0;
    bus6.out_ready = '1;
    rst_n = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_in_ready",  64'(bus.in_ready),  64'h1);
    check("rst_err",       64'(err),           64'h0);
    check("rst_done",      64'(done_cnt),      64'h0);
    check("rst_out_data",  64'(bus.out_data),  64'h0);
    check("rst_err6",      64'(err6),          64'h0);
    rst_n = 1'b1;
    tick();

    // Single NAND to channel 2, two-cycle latency
    drive(8'hF0, 8'hCC, 3'd0, 2'd2);
    check("single_in_ready", 64'(bus.in_ready), 64'h1);
    tick();
    bus.in_valid = 1'b0;
    check("single_lat1_none", 64'(bus.out_valid), 64'h0);
    tick();
    check("single_valid", 64'(bus.out_valid), 64'h4);
    check("single_data",  64'(lane(2)),       64'h3F);
    tick();
    check("single_done",  64'(done_cnt),      64'h1);
    check("single_drained", 64'(bus.out_valid), 64'h0);

    // Opcode sweep on channel 0, one transaction per cycle
    for (int c = 0; c < 9; c++) begin
      if (c < 8) drive(8'hF0, 8'hCC, 3'(c), 2'd0);
      else bus.in_valid = 1'b0;
      if (c < 8) check($sformatf("sweep_in_ready%0d", c), 64'(bus.in_ready), 64'h1);
      tick();
      if (c >= 1 && c <= 7) begin
        check($sformatf("sweep_valid%0d", c-1), 64'(bus.out_valid), 64'h1);
        check($sformatf("sweep_data%0d", c-1),  64'(lane(0)), 64'(sweep_exp[c-1]));
      end
    end
    check("sweep_illegal_no_out", 64'(bus.out_valid), 64'h0);
    check("sweep_err_set", 64'(err), 64'h1);
    tick();
    check("sweep_done", 64'(done_cnt), 64'd8);

    // Back-to-back to stalled channel 1 (OR with b=0 passes a through)
    bus.out_ready = 4'b1101;
    drive(8'hA1, 8'h00, 3'd3, 2'd1);
    tick();
    drive(8'hA2, 8'h00, 3'd3, 2'd1);
    check("b2b_ready_second", 64'(bus.in_ready), 64'h1);
    tick();
    drive(8'hA3, 8'h00, 3'd3, 2'd1);
    check("b2b_ready_blocked", 64'(bus.in_ready), 64'h0);
    check("b2b_held_valid", 64'(bus.out_valid), 64'h2);
    check("b2b_held_data",  64'(lane(1)), 64'hA1);
    tick(); tick();
    check("b2b_still_blocked", 64'(bus.in_ready), 64'h0);
    check("b2b_stable_data",   64'(lane(1)), 64'hA1);
    bus.out_ready = 4'b1111;
    #1;
    check("b2b_ready_release", 64'(bus.in_ready), 64'h1);
    tick();
    bus.in_valid = 1'b0;
    check("b2b_drain_a2_valid", 64'(bus.out_valid), 64'h2);
    check("b2b_drain_a2", 64'(lane(1)), 64'hA2);
    tick();
    check("b2b_drain_a3", 64'(lane(1)), 64'hA3);
    tick();
    check("b2b_empty", 64'(bus.out_valid), 64'h0);
    check("b2b_done",  64'(done_cnt), 64'd11);

    // Interleaved channels with channel 3 stalled
    bus.out_ready = 4'b0111;
    drive(8'h10, 8'h00, 3'd3, 2'd0); tick();
    drive(8'h20, 8'h00, 3'd3, 2'd1); tick();
    check("il_ch0", 64'(bus.out_valid), 64'h1);
    check("il_ch0_data", 64'(lane(0)), 64'h10);
    drive(8'h30, 8'h00, 3'd3, 2'd0); tick();
    check("il_ch1", 64'(bus.out_valid), 64'h2);
    check("il_ch1_data", 64'(lane(1)), 64'h20);
    drive(8'h40, 8'h00, 3'd3, 2'd3); tick();
    check("il_ch0b", 64'(bus.out_valid), 64'h1);
    check("il_ch0b_data", 64'(lane(0)), 64'h30);
    drive(8'h50, 8'h00, 3'd3, 2'd1); tick();
    check("il_ch3", 64'(bus.out_valid), 64'h8);
    check("il_ch3_data", 64'(lane(3)), 64'h40);
    drive(8'h60, 8'h00, 3'd3, 2'd3); tick();
    check("il_ch1b", 64'(bus.out_valid), 64'hA);
    check("il_ch1b_data", 64'(lane(1)), 64'h50);
    drive(8'h70, 8'h00, 3'd3, 2'd0);
    check("il_hol_block", 64'(bus.in_ready), 64'h0);
    tick();
    check("il_hol_valid", 64'(bus.out_valid), 64'h8);
    check("il_hol_still", 64'(bus.in_ready), 64'h0);
    bus.out_ready = 4'b1111;
    tick();
    bus.in_valid = 1'b0;
    check("il_nobubble_valid", 64'(bus.out_valid), 64'h8);
    check("il_nobubble_data",  64'(lane(3)), 64'h60);
    tick();
    check("il_last", 64'(bus.out_valid), 64'h1);
    check("il_last_data", 64'(lane(0)), 64'h70);
    tick();
    check("il_done", 64'(done_cnt), 64'd18);

    // Out-of-range channel on the 6-channel instance, then its top channel
    bus6.in_valid = 1'b1; bus6.in_a = 8'hF0; bus6.in_b = 8'hCC;
    bus6.in_op = 3'd2; bus6.in_ch = 3'd7;
    check("rng_accept", 64'(bus6.in_ready), 64'h1);
    tick();
    check("rng_err", 64'(err6), 64'h1);
    bus6.in_op = 3'd4; bus6.in_ch = 3'd5;
    tick();
    bus6.in_valid = 1'b0;
    check("rng_dropped", 64'(bus6.out_valid), 64'h0);
    tick();
    check("rng_ch5_valid", 64'(bus6.out_valid), 64'h20);
    check("rng_ch5_data",  64'(bus6.out_data[5*8 +: 8]), 64'h3C);
    tick();
    check("rng_done", 64'(done6), 64'h1);
    check("rng_err_sticky", 64'(err6), 64'h1);
    check("err_sticky_main", 64'(err), 64'h1);

    // Reset while S1 and two buffers hold data
    bus.out_ready = 4'b0000;
    drive(8'h11, 8'h00, 3'd3, 2'd0); tick();
    drive(8'h22, 8'h00, 3'd3, 2'd1); tick();
    drive(8'h33, 8'h00, 3'd3, 2'd2); tick();
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 64'(bus.out_valid), 64'h3);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 64'(bus.out_valid), 64'h0);
    check("mid_rst_ready", 64'(bus.in_ready),  64'h1);
    check("mid_rst_done",  64'(done_cnt),      64'h0);
    check("mid_rst_err",   64'(err),           64'h0);
    rst_n = 1'b1;
    bus.out_ready = 4'b1111;
    tick(); tick();
    check("post_rst_discard", 64'(bus.out_valid), 64'h0);
    check("post_rst_done",    64'(done_cnt),      64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
